// File: rtl/ccip_intf_pipe.sv
// CCI-P interface pipeline: registered Rx/Tx valid/payload chains,
// stretched AFU soft reset, power-state copy and sticky error flag.
module ccip_intf_pipe #(
  parameter int RX_W      = 552,
  parameter int RX_VW     = 2,
  parameter int TX_W      = 640,
  parameter int TX_VW     = 3,
  parameter int RX_STAGES = 1,
  parameter int TX_STAGES = 1,
  parameter int RST_HOLD  = 16
) (
  input  logic             pClk,
  input  logic             pck_cp2af_softReset,
  input  logic [RX_W-1:0]  rx_in_data,
  input  logic [RX_VW-1:0] rx_in_vld,
  output logic [RX_W-1:0]  rx_out_data,
  output logic [RX_VW-1:0] rx_out_vld,
  input  logic [TX_W-1:0]  tx_in_data,
  input  logic [TX_VW-1:0] tx_in_vld,
  output logic [TX_W-1:0]  tx_out_data,
  output logic [TX_VW-1:0] tx_out_vld,
  input  logic [1:0]       pwr_in,
  output logic [1:0]       pwr_out,
  input  logic             err_in,
  output logic             err_sticky,
  output logic             afu_softReset
);

  localparam logic HOLD = 1'b0;
  localparam logic RUN  = 1'b1;

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

  logic       state;
  logic [7:0] cnt;

  // Stretcher: stay in HOLD for RST_HOLD+1 edges after reset release.
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      state <= HOLD;
      cnt   <= HOLD_INIT;
    end else if (state == HOLD) begin
      if (cnt == 8'd0) begin
        state <= RUN;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  assign afu_softReset = (state == HOLD);

  logic [RX_VW-1:0] rx_vld_m;
  logic [TX_VW-1:0] tx_vld_m;

  assign rx_vld_m = rx_in_vld & ~{RX_VW{afu_softReset}};
  assign tx_vld_m = tx_in_vld & ~{TX_VW{afu_softReset}};

  logic [RX_VW-1:0] rx_vld_q [RX_STAGES];
  logic [RX_W-1:0]  rx_dat_q [RX_STAGES];

  // Rx valid chain; cleared at once by reset so nothing in flight survives.
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      for (int i = 0; i < RX_STAGES; i++) begin
        rx_vld_q[i] <= '0;
      end
    end else begin
      rx_vld_q[0] <= rx_vld_m;
      for (int i = 1; i < RX_STAGES; i++) begin
        rx_vld_q[i] <= rx_vld_q[i-1];
      end
    end
  end

  // Rx payload chain; no reset, qualified only by its valid.
  always_ff @(posedge pClk) begin
    rx_dat_q[0] <= rx_in_data;
    for (int i = 1; i < RX_STAGES; i++) begin
      rx_dat_q[i] <= rx_dat_q[i-1];
    end
  end

  assign rx_out_vld  = rx_vld_q[RX_STAGES-1];
  assign rx_out_data = rx_dat_q[RX_STAGES-1];

  generate
    if (TX_STAGES == 0) begin : g_tx_comb
      assign tx_out_vld  = tx_vld_m;
      assign tx_out_data = tx_in_data;
    end else begin : g_tx_reg
      logic [TX_VW-1:0] tx_vld_q [TX_STAGES];
      logic [TX_W-1:0]  tx_dat_q [TX_STAGES];

      // Tx valid chain with immediate flush on reset.
      always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) begin
          for (int i = 0; i < TX_STAGES; i++) begin
            tx_vld_q[i] <= '0;
          end
        end else begin
          tx_vld_q[0] <= tx_vld_m;
          for (int i = 1; i < TX_STAGES; i++) begin
            tx_vld_q[i] <= tx_vld_q[i-1];
          end
        end
      end

      // Tx payload chain without reset.
      always_ff @(posedge pClk) begin
        tx_dat_q[0] <= tx_in_data;
        for (int i = 1; i < TX_STAGES; i++) begin
          tx_dat_q[i] <= tx_dat_q[i-1];
        end
      end

      assign tx_out_vld  = tx_vld_q[TX_STAGES-1];
      assign tx_out_data = tx_dat_q[TX_STAGES-1];
    end
  endgenerate

  // Power state copy and sticky error, both tied to the FIU reset only.
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      pwr_out    <= 2'b00;
      err_sticky <= 1'b0;
    end else begin
      pwr_out <= pwr_in;
      if (err_in) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ccip_intf_pipe.sv
// Bench for ccip_intf_pipe: two configurations driven in parallel,
// scoreboard on Rx/Tx paths, vector table for pwr/err.
module tb_ccip_intf_pipe;

  localparam int RX_W   = 552;
  localparam int RX_VW  = 2;
  localparam int TX_W   = 640;
  localparam int TX_VW  = 3;
  localparam int HOLD_A = 16;
  localparam int HOLD_B = 3;

  logic             pClk = 1'b0;
  logic             rst;
  logic [RX_W-1:0]  rx_in_data;
  logic [RX_VW-1:0] rx_in_vld;
  logic [TX_W-1:0]  tx_in_data;
  logic [TX_VW-1:0] tx_in_vld;
  logic [1:0]       pwr_in;
  logic             err_in;

  logic [RX_W-1:0]  a_rxd, b_rxd;
  logic [RX_VW-1:0] a_rxv, b_rxv;
  logic [TX_W-1:0]  a_txd, b_txd;
  logic [TX_VW-1:0] a_txv, b_txv;
  logic [1:0]       a_pwr, b_pwr;
  logic             a_err, b_err;
  logic             a_afu, b_afu;

  ccip_intf_pipe #(
    .RX_W(RX_W), .RX_VW(RX_VW), .TX_W(TX_W), .TX_VW(TX_VW),
    .RX_STAGES(3), .TX_STAGES(2), .RST_HOLD(HOLD_A)
  ) u_a (
    .pClk(pClk), .pck_cp2af_softReset(rst),
    .rx_in_data(rx_in_data), .rx_in_vld(rx_in_vld),
    .rx_out_data(a_rxd), .rx_out_vld(a_rxv),
    .tx_in_data(tx_in_data), .tx_in_vld(tx_in_vld),
    .tx_out_data(a_txd), .tx_out_vld(a_txv),
    .pwr_in(pwr_in), .pwr_out(a_pwr),
    .err_in(err_in), .err_sticky(a_err),
    .afu_softReset(a_afu)
  );

  ccip_intf_pipe #(
    .RX_W(RX_W), .RX_VW(RX_VW), .TX_W(TX_W), .TX_VW(TX_VW),
    .RX_STAGES(1), .TX_STAGES(0), .RST_HOLD(HOLD_B)
  ) u_b (
    .pClk(pClk), .pck_cp2af_softReset(rst),
    .rx_in_data(rx_in_data), .rx_in_vld(rx_in_vld),
    .rx_out_data(b_rxd), .rx_out_vld(b_rxv),
    .tx_in_data(tx_in_data), .tx_in_vld(tx_in_vld),
    .tx_out_data(b_txd), .tx_out_vld(b_txv),
    .pwr_in(pwr_in), .pwr_out(b_pwr),
    .err_in(err_in), .err_sticky(b_err),
    .afu_softReset(b_afu)
  );

  always #5 pClk = ~pClk;

  typedef struct {
    int               due;
    logic [TX_W-1:0]  d;
    logic [TX_VW-1:0] v;
  } sb_t;

  typedef struct {
    logic [1:0] rxv;
    logic [7:0] rxd;
    logic [2:0] txv;
    logic [7:0] txd;
    logic [1:0] pwr;
    logic       err;
    logic [1:0] exp_pwr;
    logic       exp_err;
  } vec_t;

  sb_t   q [4][$];
  int    lat [4] = '{3, 1, 2, 0};
  string nm [4]  = '{"rx_a", "rx_b", "tx_a", "tx_b"};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rel    = 0;

  task automatic chk(input string n, input logic [TX_W-1:0] act,
                     input logic [TX_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic push(input int k, input logic hold,
                      input logic [TX_W-1:0] d, input logic [TX_VW-1:0] v);
    sb_t e;
    if (!hold && v != '0) begin
      e.due = cyc + lat[k];
      e.d   = d;
      e.v   = v;
      q[k].push_back(e);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] rxv,
                      input logic [7:0] rxd, input logic [2:0] txv,
                      input logic [7:0] txd, input logic [1:0] pw,
                      input logic er);
    logic            ha, hb;
    sb_t             e;
    logic [TX_W-1:0] av [4];
    logic [TX_W-1:0] ad [4];
    @(negedge pClk);
    rst        = r;
    rx_in_vld  = rxv;
    rx_in_data = {69{rxd}};
    tx_in_vld  = txv;
    tx_in_data = {80{txd}};
    pwr_in     = pw;
    err_in     = er;
    cyc++;
    if (r) begin
      rel = 0;
      for (int k = 0; k < 4; k++) q[k].delete();
    end
    ha = r || (rel <= HOLD_A);
    hb = r || (rel <= HOLD_B);
    push(0, ha, TX_W'(rx_in_data), TX_VW'(rxv));
    push(1, hb, TX_W'(rx_in_data), TX_VW'(rxv));
    push(2, ha, tx_in_data, txv);
    push(3, hb, tx_in_data, txv);
    #1;
    chk("afu_a", TX_W'(a_afu), TX_W'(ha));
    chk("afu_b", TX_W'(b_afu), TX_W'(hb));
    av[0] = TX_W'(a_rxv); ad[0] = TX_W'(a_rxd);
    av[1] = TX_W'(b_rxv); ad[1] = TX_W'(b_rxd);
    av[2] = TX_W'(a_txv); ad[2] = a_txd;
    av[3] = TX_W'(b_txv); ad[3] = b_txd;
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() > 0 && q[k][0].due == cyc) begin
        e = q[k].pop_front();
        chk({nm[k], "_vld"}, av[k], TX_W'(e.v));
        chk({nm[k], "_data"}, ad[k], e.d);
      end else begin
        chk({nm[k], "_vld"}, av[k], '0);
      end
    end
    if (r) begin
      chk("rst_pwr_a", TX_W'(a_pwr), '0);
      chk("rst_pwr_b", TX_W'(b_pwr), '0);
      chk("rst_err_a", TX_W'(a_err), '0);
      chk("rst_err_b", TX_W'(b_err), '0);
    end
    if (!r && rel < 1000) rel++;
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{2'b01, 8'hA5, 3'b111, 8'h3C, 2'b10, 1'b0, 2'b00, 1'b0};
    tbl[1] = '{2'b00, 8'h00, 3'b000, 8'h00, 2'b10, 1'b0, 2'b10, 1'b0};
    tbl[2] = '{2'b10, 8'h5A, 3'b010, 8'h11, 2'b01, 1'b1, 2'b10, 1'b0};
    tbl[3] = '{2'b11, 8'hFF, 3'b100, 8'h22, 2'b01, 1'b0, 2'b01, 1'b1};
    tbl[4] = '{2'b00, 8'h00, 3'b000, 8'h00, 2'b11, 1'b0, 2'b01, 1'b1};
    tbl[5] = '{2'b00, 8'h00, 3'b000, 8'h00, 2'b00, 1'b0, 2'b11, 1'b1};
    tbl[6] = '{2'b00, 8'h00, 3'b000, 8'h00, 2'b00, 1'b0, 2'b00, 1'b1};
    tbl[7] = '{2'b01, 8'h00, 3'b001, 8'h80, 2'b00, 1'b0, 2'b00, 1'b1};

    rst        = 1'b1;
    rx_in_vld  = '0;
    rx_in_data = '0;
    tx_in_vld  = '0;
    tx_in_data = '0;
    pwr_in     = 2'b00;
    err_in     = 1'b0;
    #1;
    chk("init_afu_a", TX_W'(a_afu), TX_W'(1'b1));
    chk("init_afu_b", TX_W'(b_afu), TX_W'(1'b1));
    chk("init_rxv_a", TX_W'(a_rxv), '0);
    chk("init_txv_a", TX_W'(a_txv), '0);
    chk("init_txv_b", TX_W'(b_txv), '0);
    chk("init_pwr_a", TX_W'(a_pwr), '0);
    chk("init_err_a", TX_W'(a_err), '0);

    repeat (3) step(1'b1, 2'b00, 8'h00, 3'b000, 8'h00, 2'b00, 1'b0);

    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'b11, 8'(i + 1), 3'b111, 8'(i + 100), 2'b00, 1'b0);
    end
    repeat (4) step(1'b0, 2'b00, 8'h00, 3'b000, 8'h00, 2'b00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, tbl[i].rxv, tbl[i].rxd, tbl[i].txv, tbl[i].txd,
           tbl[i].pwr, tbl[i].err);
      chk($sformatf("pwr_a[%0d]", i), TX_W'(a_pwr), TX_W'(tbl[i].exp_pwr));
      chk($sformatf("pwr_b[%0d]", i), TX_W'(b_pwr), TX_W'(tbl[i].exp_pwr));
      chk($sformatf("err_a[%0d]", i), TX_W'(a_err), TX_W'(tbl[i].exp_err));
      chk($sformatf("err_b[%0d]", i), TX_W'(b_err), TX_W'(tbl[i].exp_err));
    end

    for (int i = 0; i < 100; i++) begin
      step(1'b0, 2'b00, 8'h00, 3'b000, 8'h00, 2'b00, 1'b0);
      chk("err_hold_a", TX_W'(a_err), TX_W'(1'b1));
      chk("err_hold_b", TX_W'(b_err), TX_W'(1'b1));
    end

    for (int i = 0; i < 10; i++) begin
      step((i == 5) || (i == 6), 2'b11, 8'(i + 1), 3'b101, 8'(i + 40),
           2'b01, 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 2'b00, 8'h00, 3'b000, 8'h00, 2'b00, 1'b0);
    end
    chk("err_after_rst_a", TX_W'(a_err), '0);
    chk("err_after_rst_b", TX_W'(b_err), '0);
    for (int k = 0; k < 4; k++) begin
      chk({nm[k], "_drained"}, TX_W'(q[k].size()), '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccip_intf_pipe.md
CCIP_INTF_PIPE -- requirements
Module: ccip_intf_pipe

Interface
REQ-001 SHALL provide parameter RX_W, default 552, meaning Rx payload width in bits.
REQ-002 SHALL provide parameter RX_VW, default 2, meaning Rx valid-vector width (one bit per channel).
REQ-003 SHALL provide parameter TX_W, default 640, meaning Tx payload width in bits.
REQ-004 SHALL provide parameter TX_VW, default 3, meaning Tx valid-vector width.
REQ-005 SHALL provide parameter RX_STAGES, default 1, legal 1..4, meaning Rx register depth.
REQ-006 SHALL provide parameter TX_STAGES, default 1, legal 0..4, meaning Tx register depth.
REQ-007 SHALL provide parameter RST_HOLD, default 16, legal 0..255, meaning extra reset-hold cycles.
REQ-008 pClk  in  1  sole clock; all state on rising edge.
REQ-009 pck_cp2af_softReset  in  1  reset; asynchronous assertion, active-high; deassertion arrives synchronous to pClk from the FIU.
REQ-010 rx_in_data  in  RX_W  Rx payload from FIU.
REQ-011 rx_in_vld  in  RX_VW  Rx per-channel valids.
REQ-012 rx_out_data  out  RX_W  Rx payload to AFU.
REQ-013 rx_out_vld  out  RX_VW  Rx valids to AFU.
REQ-014 tx_in_data  in  TX_W  Tx payload from AFU.
REQ-015 tx_in_vld  in  TX_VW  Tx valids from AFU.
REQ-016 tx_out_data  out  TX_W  Tx payload to FIU.
REQ-017 tx_out_vld  out  TX_VW  Tx valids to FIU.
REQ-018 pwr_in  in  2  power state; pwr_out out 2 registered copy.
REQ-019 err_in  in  1  protocol error; err_sticky out 1 latched error.
REQ-020 afu_softReset  out  1  stretched reset to AFU.

Function
REQ-021 Rx path SHALL be a RX_STAGES-deep register chain; rx_out_* at cycle n+RX_STAGES equal the accepted input at cycle n.
REQ-022 Tx path SHALL be a TX_STAGES-deep register chain; TX_STAGES=0 SHALL be a combinational path with only valid masking.
REQ-023 Valids entering either chain SHALL be ANDed with ~afu_softReset; payload SHALL pass unmasked.
REQ-024 Payload registers SHALL carry no reset; payload is defined only where the matching valid bit is 1.
REQ-025 Reset stretcher: state {HOLD, RUN}; 8-bit counter cnt.
REQ-026 In HOLD, afu_softReset=1; each edge with reset low: if cnt==0 go RUN, else cnt<=cnt-1.
REQ-027 afu_softReset SHALL deassert on the (RST_HOLD+1)th rising edge after pck_cp2af_softReset deasserts; RUN has no exit except reset.
REQ-028 pwr_out SHALL equal pwr_in delayed one cycle.
REQ-029 err_sticky SHALL set the edge after err_in=1 and remain 1 until reset; independent of afu_softReset.
REQ-030 Valid bits already in flight when afu_softReset is high SHALL not exist (flushed by reset, masked at input).
REQ-031 Simultaneous rx and tx traffic SHALL be independent; no back-pressure, no data loss, no reordering.

Reset
REQ-032 On pck_cp2af_softReset assertion, immediately (no clock): all valid stage bits 0, rx_out_vld=0, tx_out_vld=0, pwr_out=0, err_sticky=0, afu_softReset=1, state HOLD, cnt=RST_HOLD.
REQ-033 Reset asserted mid-burst SHALL flush all valids immediately; no partial transaction SHALL emerge after reset.
REQ-034 With TX_STAGES=0, tx_out_vld SHALL be 0 whenever afu_softReset=1.

Verification
REQ-035 RST_HOLD=16: release reset at edge 0 -> afu_softReset 1 through edge 16, 0 from edge 17.
REQ-036 RX_STAGES=3, RUN: rx_in_vld=2'b01, data=0xA5 for one cycle -> rx_out_vld=2'b01, data=0xA5 exactly 3 cycles later, 0 otherwise.
REQ-037 TX_STAGES=0/2: tx_in_vld=3'b111 during HOLD -> tx_out_vld stays 0; same stimulus in RUN -> 3'b111 after 0/2 cycles.
REQ-038 Back-to-back Rx valids 10 cycles with incrementing data, reset asserted at cycle 5 -> outputs 0 immediately, no valid until afu_softReset deasserts.
REQ-039 err_in pulse 1 cycle -> err_sticky=1 next edge, stays 1 for 100 cycles, clears only on reset; pwr_in=2'b10 -> pwr_out=2'b10 one cycle later.
